// File: rtl/io_test_scope_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_test_scope_pkg
// Brief    : Shared types and constants for the test-probe capture scope.
// Revision : 1.0 - initial release
// ============================================================================
package io_test_scope_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } scopeState_t;

    localparam logic [1:0] c_offCtrl = 2'd0;
    localparam logic [1:0] c_offTrig = 2'd1;
    localparam logic [1:0] c_offPost = 2'd2;
    localparam logic [1:0] c_offData = 2'd3;

    localparam int c_ctrlArmBit   = 0;
    localparam int c_ctrlAbortBit = 1;
    localparam int c_trigEdgeBit  = 32;

    function automatic logic isCapturing(input scopeState_t s);
        return (s == ST_FILL) || (s == ST_WAIT) || (s == ST_POST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_test_scope_if.sv
`default_nettype none
// ============================================================================
// Module   : io_test_scope_if
// Brief    : PC-side IO bus bundle between the host master and the scope.
// Revision : 1.0 - initial release
// ============================================================================
interface io_test_scope_if;

    logic [15:0] AIoAddr;
    logic [63:0] AIoMiso;
    logic [63:0] AIoMosi;
    logic [3:0]  AIoWrSize;
    logic [3:0]  AIoRdSize;
    logic        AIoAddrAck;
    logic        AIoAddrErr;

    modport master (
        output AIoAddr, AIoMosi, AIoWrSize, AIoRdSize,
        input  AIoMiso, AIoAddrAck, AIoAddrErr
    );

    modport slave (
        input  AIoAddr, AIoMosi, AIoWrSize, AIoRdSize,
        output AIoMiso, AIoAddrAck, AIoAddrErr
    );

endinterface
`default_nettype wire

// File: rtl/io_test_scope_ram.sv
`default_nettype none
// ============================================================================
// Module   : scope_ram
// Brief    : 16-bit simple dual-port sample buffer, registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module scope_ram #(
    parameter int ADDR_W = 10
) (
    input  wire logic              clk,
    input  wire logic              i_wrEn,
    input  wire logic [ADDR_W-1:0] i_wrAddr,
    input  wire logic [15:0]       i_wrData,
    input  wire logic [ADDR_W-1:0] i_rdAddr,
    output logic      [15:0]       o_rdData
);

    localparam int c_depth = 1 << ADDR_W;

    // No reset on the array or read register so the tools map it to block RAM.
    logic [15:0] r_mem [0:c_depth-1];

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
        o_rdData <= r_mem[i_rdAddr];
    end

endmodule
`default_nettype wire

// File: rtl/io_test_scope.sv
`default_nettype none
// ============================================================================
// Module   : io_test_scope
// Brief    : Triggered circular capture of the 16-bit test probe, IO readout.
// Revision : 1.0 - initial release
// ============================================================================
module io_test_scope
    import io_test_scope_pkg::*;
#(
    parameter logic [15:0] CAddrBase = 16'h0000,
    parameter int          CBufAw    = 10
) (
    input  wire logic        AClkH,
    input  wire logic        AResetHN,
    input  wire logic        AClkHEn,
    io_test_scope_if.slave   io,
    input  wire logic [15:0] ATest16p,
    output logic             AScopeIrq
);

    localparam logic [CBufAw-1:0] c_ptrMax = '1;
    localparam logic [CBufAw-1:0] c_ptrOne = CBufAw'(1);

    scopeState_t       r_state;
    scopeState_t       w_stateNext;

    logic [15:0]       r_cfgMask;
    logic [15:0]       r_cfgValue;
    logic              r_cfgEdge;
    logic [CBufAw-1:0] r_cfgPost;

    logic [15:0]       r_shMask;
    logic [15:0]       r_shValue;
    logic              r_shEdge;
    logic [CBufAw-1:0] r_shPost;
    logic [CBufAw-1:0] r_fillLen;

    logic [CBufAw-1:0] r_wrPtr;
    logic [CBufAw-1:0] r_rdPtr;
    logic [CBufAw-1:0] r_fillCnt;
    logic [CBufAw-1:0] r_postLeft;
    logic [CBufAw-1:0] r_trigIdx;
    logic              r_prevHit;

    logic [15:0]       w_offFull;
    logic [1:0]        w_off;
    logic              w_hit;
    logic              w_wrAcc;
    logic              w_rdAcc;
    logic              w_arm;
    logic              w_abort;
    logic              w_armStart;
    logic [CBufAw-1:0] w_armFillLen;
    logic              w_sample;
    logic              w_levelHit;
    logic              w_trigHit;
    logic              w_pop;
    logic [15:0]       w_ramRdData;
    logic [63:0]       w_statusWord;
    logic [63:0]       w_miso;
    logic              w_unusedMosi;

    // Address decode; the reset term keeps the bus outputs quiet during reset.
    assign w_offFull = io.AIoAddr - CAddrBase;
    assign w_hit     = AResetHN && (w_offFull[15:2] == 14'd0);
    assign w_off     = w_offFull[1:0];
    assign w_wrAcc   = w_hit && (|io.AIoWrSize);
    assign w_rdAcc   = w_hit && (|io.AIoRdSize);

    assign io.AIoAddrAck = w_wrAcc || w_rdAcc;
    assign io.AIoAddrErr = (w_wrAcc && (w_off == c_offData)) ||
                           (w_rdAcc && ((w_off == c_offTrig) || (w_off == c_offPost)));

    assign w_arm        = w_wrAcc && (w_off == c_offCtrl) && io.AIoMosi[c_ctrlArmBit];
    assign w_abort      = w_wrAcc && (w_off == c_offCtrl) && io.AIoMosi[c_ctrlAbortBit];
    assign w_armStart   = w_arm && !w_abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_armFillLen = c_ptrMax - r_cfgPost;

    assign w_sample   = AClkHEn && isCapturing(r_state);
    assign w_levelHit = ((ATest16p ^ r_shValue) & r_shMask) == 16'd0;
    assign w_trigHit  = w_levelHit && (!r_shEdge || !r_prevHit);
    assign w_pop      = w_rdAcc && (w_off == c_offData) && (r_state == ST_DONE);

    assign w_unusedMosi = ^io.AIoMosi[63:33];

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_armStart) begin
                    w_stateNext = (w_armFillLen == '0) ? ST_WAIT : ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_sample && (r_fillCnt == (r_fillLen - c_ptrOne))) begin
                    w_stateNext = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_sample && w_trigHit) begin
                    w_stateNext = (r_shPost == '0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (w_sample && (r_postLeft == c_ptrOne)) begin
                    w_stateNext = ST_DONE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
        if (w_abort) begin
            w_stateNext = ST_IDLE;
        end
    end

    always_ff @(posedge AClkH) begin
        if (!AResetHN) begin
            r_state    <= ST_IDLE;
            r_cfgMask  <= '0;
            r_cfgValue <= '0;
            r_cfgEdge  <= 1'b0;
            r_cfgPost  <= '0;
            r_shMask   <= '0;
            r_shValue  <= '0;
            r_shEdge   <= 1'b0;
            r_shPost   <= '0;
            r_fillLen  <= '0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_fillCnt  <= '0;
            r_postLeft <= '0;
            r_trigIdx  <= '0;
            r_prevHit  <= 1'b0;
        end else begin
            r_state <= w_stateNext;

            if (w_wrAcc && (w_off == c_offTrig)) begin
                r_cfgMask  <= io.AIoMosi[15:0];
                r_cfgValue <= io.AIoMosi[31:16];
                r_cfgEdge  <= io.AIoMosi[c_trigEdgeBit];
            end
            if (w_wrAcc && (w_off == c_offPost)) begin
                r_cfgPost <= io.AIoMosi[CBufAw-1:0];
            end

            // Edge history follows every enabled sample, so a level already
            // true when arming does not count as an edge.
            if (AClkHEn) begin
                r_prevHit <= w_levelHit;
            end

            if (w_sample) begin
                r_wrPtr <= r_wrPtr + c_ptrOne;
                if (r_state == ST_FILL) begin
                    r_fillCnt <= r_fillCnt + c_ptrOne;
                end
                if ((r_state == ST_WAIT) && w_trigHit) begin
                    r_trigIdx  <= r_wrPtr;
                    r_postLeft <= r_shPost;
                end
                if (r_state == ST_POST) begin
                    r_postLeft <= r_postLeft - c_ptrOne;
                end
            end

            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_ptrOne;
            end
            // DONE is only entered on a sample, so the oldest entry is the
            // slot after the one being written now.
            if ((w_stateNext == ST_DONE) && (r_state != ST_DONE)) begin
                r_rdPtr <= r_wrPtr + c_ptrOne;
            end

            if (w_armStart) begin
                r_wrPtr   <= '0;
                r_rdPtr   <= '0;
                r_fillCnt <= '0;
                r_shMask  <= r_cfgMask;
                r_shValue <= r_cfgValue;
                r_shEdge  <= r_cfgEdge;
                r_shPost  <= r_cfgPost;
                r_fillLen <= w_armFillLen;
            end
        end
    end

    scope_ram #(
        .ADDR_W (CBufAw)
    ) u_ram (
        .clk      (AClkH),
        .i_wrEn   (w_sample),
        .i_wrAddr (r_wrPtr),
        .i_wrData (ATest16p),
        .i_rdAddr (r_rdPtr),
        .o_rdData (w_ramRdData)
    );

    assign w_statusWord = (64'(r_trigIdx) << 16) | 64'(r_state);

    always_comb begin
        w_miso = '0;
        if (w_rdAcc) begin
            case (w_off)
                c_offCtrl: w_miso = w_statusWord;
                c_offData: w_miso = (r_state == ST_DONE) ? {48'd0, w_ramRdData} : 64'd0;
                default:   w_miso = '0;
            endcase
        end
    end

    assign io.AIoMiso = w_miso;
    assign AScopeIrq  = (r_state == ST_DONE);

endmodule
`default_nettype wire
